golden_nonce_reporter: RTL and testbench

//  Sits between fpgaminer_top and the UART transmit byte path in the hash_clk domain.
//  - Captures every golden nonce pulse into a small FIFO so bursts are not lost.
//  - Serialises each queued nonce into a byte frame with a valid/ready handshake.
//  - Flushes stale results when new work arrives and reports drops.

---
 rtl/golden_nonce_reporter.sv | 167 ++++++++++++++++
 tb/tb_golden_nonce_reporter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/golden_nonce_reporter.sv
// Golden nonce FIFO plus byte serializer feeding the UART transmit path (hash_clk domain).
// Optional checksum byte: define GOLDEN_NONCE_CHK_EN for 5-byte frames (4 nonce bytes + XOR).
module golden_nonce_reporter #(
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  hash_clk,
  input  logic                  reset,
  input  logic                  new_golden_nonce,
  input  logic [31:0]           golden_nonce,
  input  logic                  new_work,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [DEPTH_LOG2:0]   queue_level,
  output logic                  overflow,
  output logic [7:0]            drop_count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SEND
`ifdef GOLDEN_NONCE_CHK_EN
    , CHK
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   count_q;
  logic            overflow_q;
  logic [7:0]      drop_q;
  logic [31:0]     shift_q, shift_d;
  logic [1:0]      idx_q, idx_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
`ifdef GOLDEN_NONCE_CHK_EN
  logic [7:0]      csum_q, csum_d;
`endif

  logic full_c, empty_c, pop_c, push_c, drop_c;

  assign full_c  = (count_q == FULL_LVL);
  assign empty_c = (count_q == '0);
  // A flush swallows any nonce arriving in the same cycle without counting it.
  assign push_c  = new_golden_nonce && !new_work && (!full_c || pop_c);
  assign drop_c  = new_golden_nonce && !new_work && full_c && !pop_c;

  always_ff @(posedge hash_clk) begin
    if (push_c) mem_q[wr_ptr_q] <= golden_nonce;
  end

  // FIFO pointers, level and drop accounting.
  always_ff @(posedge hash_clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= 8'h00;
    end else begin
      if (new_work) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
        case ({push_c, pop_c})
          2'b10:   count_q <= count_q + LW'(1);
          2'b01:   count_q <= count_q - LW'(1);
          default: count_q <= count_q;
        endcase
      end
      if (drop_c) begin
        overflow_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= 32'h0;
      idx_q      <= 2'd0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
`ifdef GOLDEN_NONCE_CHK_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
`ifdef GOLDEN_NONCE_CHK_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Serializer next state; tx outputs are precomputed so they leave registers.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    pop_c      = 1'b0;
    tx_valid_d = 1'b0;
    tx_data_d  = 8'h00;
`ifdef GOLDEN_NONCE_CHK_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (!empty_c && !new_work) begin
          pop_c   = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          idx_d   = 2'd0;
          state_d = SEND;
`ifdef GOLDEN_NONCE_CHK_EN
          csum_d  = shift_d[31:24] ^ shift_d[23:16] ^ shift_d[15:8] ^ shift_d[7:0];
`endif
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (idx_q == 2'd3) begin
`ifdef GOLDEN_NONCE_CHK_EN
            state_d = CHK;
`else
            state_d = IDLE;
`endif
          end else begin
            shift_d = {shift_q[23:0], 8'h00};
            idx_d   = idx_q + 2'd1;
          end
        end
      end
`ifdef GOLDEN_NONCE_CHK_EN
      CHK: begin
        if (tx_ready) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    tx_valid_d = (state_d != IDLE);
    if (state_d == SEND) tx_data_d = shift_d[31:24];
`ifdef GOLDEN_NONCE_CHK_EN
    else if (state_d == CHK) tx_data_d = csum_d;
`endif
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign queue_level = count_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_golden_nonce_reporter.sv
// Directed bench for golden_nonce_reporter: per-cycle vector table plus multi-cycle corner sequences.
module tb_golden_nonce_reporter;

`ifdef GOLDEN_NONCE_CHK_EN
  localparam int FRAME = 5;
`else
  localparam int FRAME = 4;
`endif

  logic        hash_clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_golden_nonce = 1'b0;
  logic [31:0] golden_nonce = 32'h0;
  logic        new_work = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [2:0]  queue_level;
  logic        overflow;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;

  golden_nonce_reporter #(.DEPTH_LOG2(2)) dut (
    .hash_clk(hash_clk), .reset(reset), .new_golden_nonce(new_golden_nonce),
    .golden_nonce(golden_nonce), .new_work(new_work), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .queue_level(queue_level),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 hash_clk = ~hash_clk;

  // Bytes actually accepted by the transmitter.
  logic [7:0] got[$];
  logic [7:0] exp_b[$];
  always @(negedge hash_clk) begin
    if (!reset && tx_valid && tx_ready) got.push_back(tx_data);
  end

  typedef struct {
    logic        ngn;
    logic [31:0] nonce;
    logic        nw;
    logic        rdy;
    logic        ev;
    logic [7:0]  ed;
    logic [2:0]  el;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic ngn, input logic [31:0] n, input logic rdy,
                     input logic ev, input logic [7:0] ed, input logic [2:0] el);
    vec_t v;
    v.ngn = ngn; v.nonce = n; v.nw = 1'b0; v.rdy = rdy; v.ev = ev; v.ed = ed; v.el = el;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge hash_clk);
    #1;
  endtask

  task automatic cyc(input logic ngn, input logic [31:0] n, input logic nw);
    new_golden_nonce = ngn; golden_nonce = n; new_work = nw;
    step();
    new_golden_nonce = 1'b0; new_work = 1'b0;
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1; new_golden_nonce = 1'b0; new_work = 1'b0; tx_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    chk({name, "_valid"}, 32'(tx_valid), 0);
    chk({name, "_data"}, 32'(tx_data), 0);
    chk({name, "_level"}, 32'(queue_level), 0);
    chk({name, "_ovf"}, 32'(overflow), 0);
    chk({name, "_drop"}, 32'(drop_count), 0);
    got.delete(); exp_b.delete();
  endtask

  function automatic void add_frame(input logic [31:0] n);
    exp_b.push_back(n[31:24]); exp_b.push_back(n[23:16]);
    exp_b.push_back(n[15:8]);  exp_b.push_back(n[7:0]);
`ifdef GOLDEN_NONCE_CHK_EN
    exp_b.push_back(n[31:24] ^ n[23:16] ^ n[15:8] ^ n[7:0]);
`endif
  endfunction

  task automatic cmp_bytes(input string name);
    int n;
    chk({name, "_nbytes"}, 32'(got.size()), 32'(exp_b.size()));
    n = (got.size() < exp_b.size()) ? got.size() : exp_b.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_byte%0d", name, i), 32'(got[i]), 32'(exp_b[i]));
    got.delete(); exp_b.delete();
  endtask

  logic [31:0] nn [6];
  bit ok;

  initial begin
    // Single frame with ready held high, then a 10-cycle stall on byte 2.
    add(1, 32'hDEADBEEF, 1, 0, 8'h00, 1);
    add(0, 0, 1, 1, 8'hDE, 0);
    add(0, 0, 1, 1, 8'hAD, 0);
    add(0, 0, 1, 1, 8'hBE, 0);
    add(0, 0, 1, 1, 8'hEF, 0);
`ifdef GOLDEN_NONCE_CHK_EN
    add(0, 0, 1, 1, 8'h22, 0);
`endif
    add(0, 0, 1, 0, 8'h00, 0);
    add(0, 0, 1, 0, 8'h00, 0);
    add(1, 32'hDEADBEEF, 1, 0, 8'h00, 1);
    add(0, 0, 1, 1, 8'hDE, 0);
    add(0, 0, 1, 1, 8'hAD, 0);
    for (int i = 0; i < 10; i++) add(0, 0, 0, 1, 8'hAD, 0);
    add(0, 0, 1, 1, 8'hBE, 0);
    add(0, 0, 1, 1, 8'hEF, 0);
`ifdef GOLDEN_NONCE_CHK_EN
    add(0, 0, 1, 1, 8'h22, 0);
`endif
    add(0, 0, 1, 0, 8'h00, 0);

    do_reset("rst0");
    foreach (vecs[i]) begin
      tx_ready = vecs[i].rdy;
      cyc(vecs[i].ngn, vecs[i].nonce, vecs[i].nw);
      chk($sformatf("vec%0d_valid", i), 32'(tx_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_data", i), 32'(tx_data), 32'(vecs[i].ed));
      chk($sformatf("vec%0d_level", i), 32'(queue_level), 32'(vecs[i].el));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 0);
    end
    add_frame(32'hDEADBEEF); add_frame(32'hDEADBEEF);
    cmp_bytes("table");

    // Burst of 6 with ready low: one in flight, four queued, one dropped.
    do_reset("rst3");
    for (int i = 0; i < 6; i++) nn[i] = 32'hA1B2C3D0 + 32'(i);
    for (int i = 0; i < 6; i++) cyc(1, nn[i], 0);
    chk("t3_level", 32'(queue_level), 4);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_drop", 32'(drop_count), 1);
    chk("t3_valid", 32'(tx_valid), 1);
    chk("t3_data", 32'(tx_data), 32'hA1);
    tx_ready = 1'b1;
    for (int i = 0; i < 60; i++) step();
    for (int i = 0; i < 5; i++) add_frame(nn[i]);
    cmp_bytes("t3_drain");
    chk("t3_ovf_sticky", 32'(overflow), 1);

    // Saturating drop counter; flush keeps it and ignores the coincident nonce.
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1, 32'h55000000 + 32'(i), 0);
    for (int i = 0; i < 260; i++) cyc(1, 32'h66000000, 0);
    chk("sat_drop", 32'(drop_count), 255);
    chk("sat_level", 32'(queue_level), 4);
    cyc(1, 32'h77777777, 1);
    chk("sat_flush_level", 32'(queue_level), 0);
    chk("sat_flush_drop", 32'(drop_count), 255);
    chk("sat_flush_ovf", 32'(overflow), 1);
    tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    add_frame(32'h55000000);
    cmp_bytes("sat_inflight");

    // Flush while a frame is in flight with three queued behind it.
    do_reset("rst4");
    tx_ready = 1'b1;
    cyc(1, 32'h0BADF00D, 0);
    cyc(1, 32'h11111111, 0);
    cyc(1, 32'h22222222, 0);
    cyc(1, 32'h33333333, 0);
    chk("t4_level_pre", 32'(queue_level), 3);
    cyc(1, 32'h44444444, 1);
    chk("t4_level_flush", 32'(queue_level), 0);
    chk("t4_drop", 32'(drop_count), 0);
    for (int i = 0; i < 30; i++) step();
    add_frame(32'h0BADF00D);
    cmp_bytes("t4_frames");
    chk("t4_level_end", 32'(queue_level), 0);

    // Push accepted into a full FIFO in the very cycle the serializer pops.
    do_reset("rst5");
    for (int i = 0; i < 6; i++) nn[i] = 32'hC0000000 + 32'(i * 32'h01010101);
    for (int i = 0; i < 5; i++) cyc(1, nn[i], 0);
    chk("t5_full", 32'(queue_level), 4);
    tx_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!tx_valid) begin ok = 1'b1; break; end
    end
    chk("t5_idle_reached", 32'(ok), 1);
    chk("t5_level_idle", 32'(queue_level), 4);
    cyc(1, nn[5], 0);
    chk("t5_level_after", 32'(queue_level), 4);
    chk("t5_ovf", 32'(overflow), 0);
    chk("t5_drop", 32'(drop_count), 0);
    chk("t5_valid", 32'(tx_valid), 1);
    for (int i = 0; i < 60; i++) step();
    for (int i = 0; i < 6; i++) add_frame(nn[i]);
    cmp_bytes("t5_frames");

    // Reset after two bytes of a frame: no trailing bytes, queued entry lost.
    do_reset("rst6");
    tx_ready = 1'b1;
    cyc(1, 32'hCAFEF00D, 0);
    cyc(1, 32'h01020304, 0);
    chk("t6_first", 32'(tx_data), 32'hCA);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("t6_byte2", 32'(tx_data), 32'hF0);
    chk("t6_level", 32'(queue_level), 1);
    reset = 1'b1;
    step();
    chk("t6_rst_valid", 32'(tx_valid), 0);
    chk("t6_rst_data", 32'(tx_data), 0);
    chk("t6_rst_level", 32'(queue_level), 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) step();
    exp_b.push_back(8'hCA); exp_b.push_back(8'hFE);
    cmp_bytes("t6_bytes");
    chk("t6_idle_valid", 32'(tx_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
